refclk_phase_gen: RTL and testbench

//  Parametrised multi-phase reference clock generator for the AFC loop.
//  - Produces NUM_PH registered, equally spaced phases of one divided clock, all in the clk domain.
//  - Uses no derived clocks and no ripple dividers.
//  - Runs only while afctrigger is high.
//  - Every phase starts and stops with whole pulses only: no runts on enable or disable.
//  - Feeds the AFC frequency comparator in place of the fixed div2/div4 quadrature source.

---
 rtl/refclk_phase_gen.sv | 158 +++++++++++++++
 tb/tb_refclk_phase_gen.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/refclk_phase_gen.sv
// Multi-phase reference clock generator: NUM_PH equally spaced phases of one divided clock, all registered in clk.
// Latency: refclk[0] is high in the first cycle after afctrigger is sampled high; all outputs are registered.
// Backpressure: none. Outputs run freely while enabled, and a stop drains to whole pulses before going idle.
//
// Ports:
//   clk, rst      system clock; asynchronous active-high reset
//   afctrigger    level enable (1 = run, 0 = stop after the in-flight pulses complete)
//   div_step      cycles per phase step (0 behaves as 1), latched on start
//   refclk        NUM_PH phase outputs; bit k lags bit 0 by k*360/NUM_PH degrees
//   busy          high whenever the generator is not idle
//   period_tick   one-cycle pulse on the last cycle of each period and on the drain exit
//   edge_cnt      rising edges of refclk[0] since the last start, saturating
//                 (present only with REFCLK_EDGE_CNT_EN defined, otherwise tied to 0)
module refclk_phase_gen #(
    parameter int NUM_PH = 4,
    parameter int DIV_W  = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              afctrigger,
    input  logic [DIV_W-1:0]  div_step,
    output logic [NUM_PH-1:0] refclk,
    output logic              busy,
    output logic              period_tick,
    output logic [CNT_W-1:0]  edge_cnt
);

    localparam int NSTEP = 2 * NUM_PH;
    localparam int IW    = $clog2(NSTEP);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t            state, state_d;
    logic [DIV_W-1:0]  s_lat, s_lat_d;
    logic [DIV_W-1:0]  scnt, scnt_d, scnt_step;
    logic [IW-1:0]     idx, idx_d, idx_step;
    logic [NUM_PH-1:0] mask, mask_d, mask_upd, rise_at;
    logic [NUM_PH-1:0] refclk_d;
    logic              busy_d, tick_d;
    logic              step_last;
    logic [DIV_W-1:0]  s_eff;

    // A zero step would never advance; treat it as a single-cycle step.
    assign s_eff = (div_step == '0) ? DIV_W'(1) : div_step;

    // Phase k is high for the NUM_PH steps starting at step 2k.
    function automatic logic [NUM_PH-1:0] phase_raw(input logic [IW-1:0] i);
        int d;
        phase_raw = '0;
        for (int k = 0; k < NUM_PH; k++) begin
            d = int'(i) - 2 * k;
            if (d < 0) begin
                d = d + NSTEP;
            end
            phase_raw[k] = (d < NUM_PH);
        end
    endfunction

    // Position (idx, scnt) of the cycle that follows the coming edge.
    always_comb begin
        step_last = (scnt == s_lat - DIV_W'(1));
        scnt_step = scnt + DIV_W'(1);
        idx_step  = idx;
        if (step_last) begin
            scnt_step = '0;
            idx_step  = (idx == IW'(NSTEP - 1)) ? '0 : idx + IW'(1);
        end
        rise_at = '0;
        for (int k = 0; k < NUM_PH; k++) begin
            rise_at[k] = (scnt_step == '0) && (idx_step == IW'(2 * k));
        end
        // Masks only change at a phase's own rise point, so every pulse that
        // starts also finishes; the enable level picks arm versus retire.
        mask_upd = afctrigger ? (mask | rise_at) : (mask & ~rise_at);
    end

    always_comb begin
        state_d  = IDLE;
        s_lat_d  = s_lat;
        scnt_d   = '0;
        idx_d    = '0;
        mask_d   = '0;
        refclk_d = '0;
        busy_d   = 1'b0;
        tick_d   = 1'b0;
        case (state)
            IDLE: begin
                if (afctrigger) begin
                    state_d     = RUN;
                    s_lat_d     = s_eff;
                    mask_d      = NUM_PH'(1);
                    refclk_d    = NUM_PH'(1);
                    busy_d      = 1'b1;
                end
            end
            RUN, DRAIN: begin
                if (!afctrigger && (mask_upd == '0)) begin
                    // Last phase retired: go idle and flag the exit.
                    state_d = IDLE;
                    tick_d  = 1'b1;
                end else begin
                    state_d  = afctrigger ? RUN : DRAIN;
                    scnt_d   = scnt_step;
                    idx_d    = idx_step;
                    mask_d   = mask_upd;
                    refclk_d = phase_raw(idx_step) & mask_upd;
                    busy_d   = 1'b1;
                    tick_d   = (idx_step == IW'(NSTEP - 1)) &&
                               (scnt_step == s_lat - DIV_W'(1));
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            s_lat       <= '0;
            scnt        <= '0;
            idx         <= '0;
            mask        <= '0;
            refclk      <= '0;
            busy        <= 1'b0;
            period_tick <= 1'b0;
        end else begin
            state       <= state_d;
            s_lat       <= s_lat_d;
            scnt        <= scnt_d;
            idx         <= idx_d;
            mask        <= mask_d;
            refclk      <= refclk_d;
            busy        <= busy_d;
            period_tick <= tick_d;
        end
    end

`ifdef REFCLK_EDGE_CNT_EN
    // The start edge is itself a rising edge of refclk[0], so a start loads 1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            edge_cnt <= '0;
        end else if ((state == IDLE) && afctrigger) begin
            edge_cnt <= CNT_W'(1);
        end else if (refclk_d[0] && !refclk[0] && (edge_cnt != '1)) begin
            edge_cnt <= edge_cnt + CNT_W'(1);
        end
    end
`else
    assign edge_cnt = '0;
`endif

endmodule

// File: tb/tb_refclk_phase_gen.sv
module tb_refclk_phase_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        afctrigger;
    logic [7:0]  div_step;
    logic [3:0]  refclk, refclk_s;
    logic        busy, period_tick, busy_s, period_tick_s;
    logic [15:0] edge_cnt;
    logic [1:0]  edge_cnt_s;

    int n_tests = 0;
    int n_fail  = 0;

`ifdef REFCLK_EDGE_CNT_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif

    typedef struct {
        logic       afc;
        logic [7:0] div;
        logic [3:0] ref_e;
        logic       busy_e;
        logic       tick_e;
    } vec_t;

    vec_t tv[$];

    always #5 clk = ~clk;

    refclk_phase_gen #(.NUM_PH(4), .DIV_W(8), .CNT_W(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .afctrigger  (afctrigger),
        .div_step    (div_step),
        .refclk      (refclk),
        .busy        (busy),
        .period_tick (period_tick),
        .edge_cnt    (edge_cnt)
    );

    refclk_phase_gen #(.NUM_PH(4), .DIV_W(8), .CNT_W(2)) dut_sat (
        .clk         (clk),
        .rst         (rst),
        .afctrigger  (afctrigger),
        .div_step    (div_step),
        .refclk      (refclk_s),
        .busy        (busy_s),
        .period_tick (period_tick_s),
        .edge_cnt    (edge_cnt_s)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Inputs are those sampled at the end of the cycle; expected values are this cycle's outputs.
    task automatic add(input logic a, input logic [7:0] d, input logic [3:0] r,
                       input logic b, input logic t);
        vec_t v;
        v.afc = a; v.div = d; v.ref_e = r; v.busy_e = b; v.tick_e = t;
        tv.push_back(v);
    endtask

    // Ideal waveform c cycles after a start with step s: phase k rises at 2*s*k,
    // period 8*s, high for 4*s.
    function automatic logic [3:0] wave(input int c, input int s);
        int off;
        wave = '0;
        for (int k = 0; k < 4; k++) begin
            off = 2 * s * k;
            wave[k] = (c >= off) && (((c - off) % (8 * s)) < 4 * s);
        end
    endfunction

    initial begin
        rst = 1'b1; afctrigger = 1'b0; div_step = 8'd1;

        // idle, then start with step 1; two periods; stop at idx 5 and drain
        add(1, 8'd1, 4'h0, 0, 0);
        add(1, 8'd1, 4'h1, 1, 0); add(1, 8'd1, 4'h1, 1, 0);
        add(1, 8'd1, 4'h3, 1, 0); add(1, 8'd1, 4'h3, 1, 0);
        add(1, 8'd1, 4'h6, 1, 0); add(1, 8'd1, 4'h6, 1, 0);
        add(1, 8'd1, 4'hC, 1, 0); add(1, 8'd1, 4'hC, 1, 1);
        add(1, 8'd1, 4'h9, 1, 0); add(1, 8'd1, 4'h9, 1, 0);
        add(1, 8'd1, 4'h3, 1, 0); add(1, 8'd1, 4'h3, 1, 0);
        add(1, 8'd1, 4'h6, 1, 0); add(0, 8'd1, 4'h6, 1, 0);
        add(0, 8'd1, 4'h4, 1, 0); add(0, 8'd1, 4'h4, 1, 1);
        add(0, 8'd1, 4'h0, 1, 0); add(0, 8'd1, 4'h0, 1, 0);
        add(0, 8'd1, 4'h0, 1, 0); add(0, 8'd1, 4'h0, 1, 0);
        add(0, 8'd1, 4'h0, 0, 1); add(1, 8'd0, 4'h0, 0, 0);
        // restart with step 0 (behaves as 1)
        add(1, 8'd0, 4'h1, 1, 0); add(1, 8'd0, 4'h1, 1, 0);
        add(1, 8'd0, 4'h3, 1, 0); add(1, 8'd0, 4'h3, 1, 0);
        add(1, 8'd0, 4'h6, 1, 0); add(1, 8'd0, 4'h6, 1, 0);
        add(1, 8'd0, 4'hC, 1, 0); add(1, 8'd0, 4'hC, 1, 1);
        // drop for two cycles and re-raise: phase 1 misses one rise, no slip
        add(1, 8'd0, 4'h9, 1, 0); add(0, 8'd0, 4'h9, 1, 0);
        add(0, 8'd0, 4'h1, 1, 0); add(1, 8'd0, 4'h1, 1, 0);
        // div_step change while running is ignored
        add(1, 8'd5, 4'h4, 1, 0); add(1, 8'd5, 4'h4, 1, 0);
        add(1, 8'd5, 4'hC, 1, 0); add(1, 8'd5, 4'hC, 1, 1);
        add(1, 8'd5, 4'h9, 1, 0); add(1, 8'd5, 4'h9, 1, 0);
        add(1, 8'd5, 4'h3, 1, 0); add(1, 8'd5, 4'h3, 1, 0);
        add(1, 8'd5, 4'h6, 1, 0); add(1, 8'd5, 4'h6, 1, 0);
        add(1, 8'd5, 4'hC, 1, 0); add(0, 8'd5, 4'hC, 1, 1);
        // stop at idx 7: phase 3 completes its pulse, then drain to idle
        add(0, 8'd5, 4'h8, 1, 0); add(0, 8'd5, 4'h8, 1, 0);
        add(0, 8'd5, 4'h0, 1, 0); add(0, 8'd5, 4'h0, 1, 0);
        add(0, 8'd5, 4'h0, 1, 0); add(0, 8'd5, 4'h0, 1, 0);
        add(1, 8'd5, 4'h0, 0, 1);

        repeat (2) @(negedge clk);
        check("rst refclk", 32'(refclk), 32'h0);
        check("rst busy", 32'(busy), 32'h0);
        check("rst tick", 32'(period_tick), 32'h0);
        check("rst edge_cnt", 32'(edge_cnt), 32'h0);
        rst = 1'b0;

        for (int i = 0; i < tv.size(); i++) begin
            check($sformatf("vec%0d refclk", i), 32'(refclk), 32'(tv[i].ref_e));
            check($sformatf("vec%0d busy", i), 32'(busy), 32'(tv[i].busy_e));
            check($sformatf("vec%0d tick", i), 32'(period_tick), 32'(tv[i].tick_e));
            afctrigger = tv[i].afc;
            div_step   = tv[i].div;
            @(negedge clk);
        end

        // restarted with the new step 5: P = 40
        for (int c = 0; c < 80; c++) begin
            check($sformatf("s5 c%0d refclk", c), 32'(refclk), 32'(wave(c, 5)));
            check($sformatf("s5 c%0d tick", c), 32'(period_tick), 32'((c % 40) == 39));
            @(negedge clk);
        end
        check("s5 busy before rst", 32'(busy), 32'h1);

        // reset mid-run takes effect immediately
        rst = 1'b1;
        div_step = 8'd3;
        #1;
        check("midrst refclk", 32'(refclk), 32'h0);
        check("midrst busy", 32'(busy), 32'h0);
        check("midrst tick", 32'(period_tick), 32'h0);
        check("midrst edge_cnt", 32'(edge_cnt), 32'h0);
        #2 rst = 1'b0;
        @(negedge clk);

        // step 3: P = 24, 12 high, spacing 6; ten periods for the edge counter
        for (int c = 0; c < 240; c++) begin
            check($sformatf("s3 c%0d refclk", c), 32'(refclk), 32'(wave(c, 3)));
            check($sformatf("s3 c%0d tick", c), 32'(period_tick), 32'((c % 24) == 23));
            if (c == 0) begin
                check("edge_cnt after start", 32'(edge_cnt), CNT_ON ? 32'd1 : 32'd0);
            end
            if (c == 239) begin
                check("edge_cnt 10 periods", 32'(edge_cnt), CNT_ON ? 32'd10 : 32'd0);
                check("edge_cnt saturated", 32'(edge_cnt_s), CNT_ON ? 32'd3 : 32'd0);
                check("sat inst refclk", 32'(refclk_s), 32'(wave(c, 3)));
                check("sat inst busy", 32'(busy_s), 32'h1);
                check("sat inst tick", 32'(period_tick_s), 32'h1);
            end
            @(negedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
